// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter: N valid/ready sources share one sink
// through a fully registered output stage.
module stream_rr_arbiter #(
  parameter  int DW = 8,
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_vld,
  input  logic [N*DW-1:0] s_dat,
  input  logic [N-1:0]    s_lst,
  output logic [N-1:0]    s_rdy,
  output logic            m_vld,
  output logic [DW-1:0]   m_dat,
  output logic            m_lst,
  input  logic            m_rdy,
  output logic [N-1:0]    gnt,
  output logic            busy
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          m_vld_q, m_vld_d;
  logic [DW-1:0] m_dat_q, m_dat_d;
  logic          m_lst_q, m_lst_d;

  logic          req_found;
  logic [IW-1:0] req_idx;
  logic          src_xfer;

  // First requester strictly after ptr, wrapping modulo N.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      if (!req_found && s_vld[(int'(ptr_q) + i) % N]) begin
        req_found = 1'b1;
        req_idx   = IW'((int'(ptr_q) + i) % N);
      end
    end
  end

  always_comb begin
    s_rdy = '0;
    if (state_q == LOCK) s_rdy[sel_q] = ~m_vld_q | m_rdy;
  end

  assign src_xfer = (state_q == LOCK) && s_vld[sel_q] && s_rdy[sel_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    m_vld_d = m_vld_q;
    m_dat_d = m_dat_q;
    m_lst_d = m_lst_q;

    case (state_q)
      IDLE: begin
        if (req_found) begin
          sel_d   = req_idx;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << req_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (src_xfer && s_lst[sel_q]) begin
          ptr_d   = sel_q;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output stage only reloads when the sink has taken (or never held) a beat.
    if (src_xfer) begin
      m_vld_d = 1'b1;
      m_dat_d = s_dat[int'(sel_q)*DW +: DW];
      m_lst_d = s_lst[sel_q];
    end else if (m_rdy) begin
      m_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(N-1);
      sel_q   <= '0;
      gnt_q   <= '0;
      m_vld_q <= 1'b0;
      m_dat_q <= '0;
      m_lst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      m_vld_q <= m_vld_d;
      m_dat_q <= m_dat_d;
      m_lst_q <= m_lst_d;
    end
  end

  assign m_vld = m_vld_q;
  assign m_dat = m_dat_q;
  assign m_lst = m_lst_q;
  assign gnt   = gnt_q;
  assign busy  = (state_q == LOCK);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed latency/lock/reset steps plus
// queue-based streams checked against a round-robin packet-order model.
module tb_stream_rr_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    s_vld = '0;
  logic [N*DW-1:0] s_dat = '0;
  logic [N-1:0]    s_lst = '0;
  logic [N-1:0]    s_rdy;
  logic            m_vld;
  logic [DW-1:0]   m_dat;
  logic            m_lst;
  logic            m_rdy = 1'b0;
  logic [N-1:0]    gnt;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] src_q [N][$];
  logic [8:0] exp_q [$];
  int         plen  [N][$];
  int         cyc;

  stream_rr_arbiter #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst(rst),
    .s_vld(s_vld), .s_dat(s_dat), .s_lst(s_lst), .s_rdy(s_rdy),
    .m_vld(m_vld), .m_dat(m_dat), .m_lst(m_lst), .m_rdy(m_rdy),
    .gnt(gnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_src(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    s_vld[i]          = v;
    s_dat[i*DW +: DW] = d;
    s_lst[i]          = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    s_vld = '1;
    s_lst = '1;
    m_rdy = 1'b1;
    @(negedge clk);
    chk("rst_m_vld", m_vld, 0);
    chk("rst_m_dat", m_dat, 0);
    chk("rst_m_lst", m_lst, 0);
    chk("rst_gnt",   gnt,   0);
    chk("rst_busy",  busy,  0);
    chk("rst_s_rdy", s_rdy, 0);
    s_vld = '0;
    s_lst = '0;
    s_dat = '0;
    m_rdy = 1'b0;
    rst   = 1'b0;
  endtask

  // Expected sink order: packet r of every source, sources ascending, round by round.
  task automatic build();
    int seq [N];
    int maxr;
    maxr = 0;
    exp_q.delete();
    for (int s = 0; s < N; s++) begin
      src_q[s].delete();
      seq[s] = 0;
      if (plen[s].size() > maxr) maxr = plen[s].size();
    end
    for (int r = 0; r < maxr; r++) begin
      for (int s = 0; s < N; s++) begin
        if (r < plen[s].size()) begin
          for (int b = 0; b < plen[s][r]; b++) begin
            logic [8:0] beat;
            beat = {(b == plen[s][r] - 1), 2'(s), 6'(seq[s])};
            seq[s]++;
            src_q[s].push_back(beat);
            exp_q.push_back(beat);
          end
        end
      end
    end
  endtask

  task automatic run_stream(input int rdy_pct, input int bubble_pct, input int budget,
                            output int ncyc);
    bit         mid [N];
    bit         hold;
    bit         lst_x;
    logic [8:0] held;
    logic [8:0] b;
    logic [N-1:0] x;
    hold  = 0;
    lst_x = 0;
    held  = '0;
    ncyc  = 0;
    for (int i = 0; i < N; i++) mid[i] = 0;
    while (exp_q.size() > 0 && ncyc < budget) begin
      @(negedge clk);
      if (lst_x) chk("idle_after_lst", busy, 0);
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0) begin
          b = src_q[i][0];
          set_src(i, (!mid[i]) || ($urandom_range(99) >= bubble_pct), b[7:0], b[8]);
        end else begin
          set_src(i, 1'b0, 8'($urandom), 1'($urandom));
        end
      end
      m_rdy = ($urandom_range(99) < rdy_pct);
      #1;
      chk("s_rdy_onehot0", $onehot0(s_rdy), 1);
      if (hold) chk("hold_beat", {m_lst, m_dat}, held);
      if (m_vld && m_rdy) begin
        b = exp_q.pop_front();
        chk("out_beat", {m_lst, m_dat}, b);
      end
      hold = m_vld & ~m_rdy;
      held = {m_lst, m_dat};
      x = s_vld & s_rdy;
      for (int i = 0; i < N; i++) if (x[i]) chk("gnt_on_xfer", gnt, 1 << i);
      lst_x = 0;
      @(posedge clk);
      ncyc++;
      for (int i = 0; i < N; i++) begin
        if (x[i] && src_q[i].size() > 0) begin
          b = src_q[i].pop_front();
          mid[i] = !b[8];
          if (b[8]) lst_x = 1;
        end
      end
    end
    chk("stream_done", exp_q.size(), 0);
    @(negedge clk);
    s_vld = '0;
    m_rdy = 1'b0;
  endtask

  initial begin
    // Single source 2, 3-beat packet, sink always ready.
    do_reset();
    m_rdy = 1'b1;
    set_src(2, 1'b1, 8'hA0, 1'b0);
    #1;
    chk("single_gnt_pre", gnt, 0);
    @(negedge clk);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_busy", busy, 1);
    chk("single_s_rdy", s_rdy, 4'b0100);
    chk("single_m_vld_early", m_vld, 0);
    tick();
    chk("single_m_vld", m_vld, 1);
    chk("single_a0", {m_lst, m_dat}, 9'h0A0);
    set_src(2, 1'b1, 8'hA1, 1'b0);
    tick();
    chk("single_a1", {m_lst, m_dat}, 9'h0A1);
    chk("single_gnt_mid", gnt, 4'b0100);
    set_src(2, 1'b1, 8'hA2, 1'b1);
    tick();
    chk("single_a2", {m_lst, m_dat}, 9'h1A2);
    chk("single_gnt_end", gnt, 0);
    chk("single_busy_end", busy, 0);
    set_src(2, 1'b0, 8'h00, 1'b0);
    tick();
    chk("single_m_vld_end", m_vld, 0);

    // Contention between sources 0 and 1 straight from reset.
    do_reset();
    for (int s = 0; s < N; s++) plen[s].delete();
    plen[0].push_back(2);
    plen[1].push_back(2);
    build();
    run_stream(100, 0, 50, cyc);
    chk("contention_cycles", cyc, 7);

    // Fairness: every source continuously offers single-beat packets.
    do_reset();
    for (int s = 0; s < N; s++) begin
      plen[s].delete();
      for (int r = 0; r < 3; r++) plen[s].push_back(1);
    end
    build();
    run_stream(100, 0, 100, cyc);
    chk("fairness_cycles", cyc, 25);

    // Granted source 1 stalls mid-packet while source 3 waits.
    do_reset();
    m_rdy = 1'b1;
    set_src(1, 1'b1, 8'h11, 1'b0);
    tick();
    chk("bubble_gnt", gnt, 4'b0010);
    tick();
    chk("bubble_b0", {m_lst, m_dat}, 9'h011);
    set_src(1, 1'b0, 8'h00, 1'b0);
    set_src(3, 1'b1, 8'h33, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bubble_gnt_hold", gnt, 4'b0010);
      chk("bubble_s_rdy", s_rdy, 4'b0010);
      chk("bubble_busy", busy, 1);
    end
    set_src(1, 1'b1, 8'h12, 1'b1);
    tick();
    chk("bubble_b1", {m_lst, m_dat}, 9'h112);
    chk("bubble_release", gnt, 0);
    set_src(1, 1'b0, 8'h00, 1'b0);
    tick();
    chk("bubble_gnt3", gnt, 4'b1000);
    tick();
    chk("bubble_src3", {m_vld, m_lst, m_dat}, 10'h333);
    set_src(3, 1'b0, 8'h00, 1'b0);
    tick();

    // Random packet lengths, random sink stalls, random mid-packet bubbles.
    do_reset();
    for (int s = 0; s < N; s++) begin
      int np;
      plen[s].delete();
      np = $urandom_range(6, 3);
      for (int r = 0; r < np; r++) plen[s].push_back($urandom_range(8, 1));
    end
    build();
    run_stream(50, 30, 3000, cyc);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    m_rdy = 1'b1;
    set_src(0, 1'b1, 8'h05, 1'b1);
    tick();
    tick();
    set_src(0, 1'b0, 8'h00, 1'b0);
    set_src(2, 1'b1, 8'hD0, 1'b0);
    tick();
    chk("rstmid_gnt", gnt, 4'b0100);
    tick();
    set_src(2, 1'b1, 8'hD1, 1'b0);
    tick();
    chk("rstmid_pre", {busy, m_vld, m_dat}, 10'h3D1);
    rst = 1'b1;
    #1;
    chk("rstmid_m_vld", m_vld, 0);
    chk("rstmid_gnt0",  gnt,   0);
    chk("rstmid_busy",  busy,  0);
    chk("rstmid_s_rdy", s_rdy, 0);
    set_src(2, 1'b0, 8'h00, 1'b0);
    set_src(0, 1'b1, 8'h0A, 1'b1);
    set_src(1, 1'b1, 8'h1B, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid_regrant", gnt, 4'b0001);
    tick();
    chk("rstmid_first", {m_vld, m_dat}, 9'h10A);
    s_vld = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
